stage_arbiter: RTL and testbench
================================

STAGE_ARBITER -- requirements
Module: stage_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 3: width of every data bus.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_in  input  1  requester 0 four-phase request.
REQ-005 data0_in  input  DATA_WIDTH  requester 0 data, stable while req0_in high.
REQ-006 ack0_out  output  1  acknowledge to requester 0.
REQ-007 req1_in  input  1  requester 1 four-phase request.
REQ-008 data1_in  input  DATA_WIDTH  requester 1 data, stable while req1_in high.
REQ-009 ack1_out  output  1  acknowledge to requester 1.
REQ-010 req_out  output  1  request to the shared pipeline stage.
REQ-011 data_out  output  DATA_WIDTH  data to the shared pipeline stage.
REQ-012 ack_in  input  1  acknowledge from the shared pipeline stage.
REQ-013 grant  output  2  one-hot owner of the stage (bit0 = requester 0); 2'b00 when idle.
REQ-014 xfer_cnt  output  8  count of completed transfers.

Function
REQ-015 FSM states: IDLE, SEND, RELEASE; all outputs registered.
REQ-016 IDLE, a sampled request high: select winner, data_out <= winner's data, req_out <= 1, grant <= winner, go to SEND; req_out rises one cycle after the edge sampling the request.
REQ-017 IDLE, both requests high on the same edge: winner is the requester not equal to last_served; last_served = 1 after reset, so requester 0 wins first.
REQ-018 IDLE, no request: outputs hold; data_out keeps the last transferred value.
REQ-019 SEND: req_out, data_out, grant held until ack_in sampled 1; then req_out <= 0, ack of granted requester <= 1, go to RELEASE.
REQ-020 RELEASE: ack of granted requester held 1 until granted request == 0 and ack_in == 0 on the same edge; then ack <= 0, grant <= 2'b00, last_served <= winner, xfer_cnt increments, go to IDLE.
REQ-021 A grant is never pre-empted; the losing requester waits with its request high and receives no ack.
REQ-022 A request dropped before it is sampled in IDLE is never granted.
REQ-023 Only the granted requester's ack is ever high; ack0_out and ack1_out are never high together.
REQ-024 xfer_cnt wraps 255 -> 0.
REQ-025 Minimum transfer: 3 cycles in IDLE/SEND/RELEASE with immediate ack_in/req responses; a pending second requester is granted on the edge after return to IDLE.

Reset
REQ-026 rst_n low asynchronously forces IDLE, req_out = 0, ack0_out = 0, ack1_out = 0, grant = 2'b00, data_out = 0, xfer_cnt = 0, last_served = 1.
REQ-027 Reset mid-transfer (SEND or RELEASE) aborts the transfer without incrementing xfer_cnt; after release, operation restarts from IDLE on the first rising edge.

Configuration
REQ-028 Macro STAGE_ARBITER_SYNC_EN defined: req0_in, req1_in and ack_in each pass through a two-flop synchronizer (reset to 0) before the FSM, adding 2 cycles to each handshake response.
REQ-029 Macro STAGE_ARBITER_SYNC_EN undefined: the FSM samples req0_in, req1_in and ack_in directly; latencies per REQ-016 to REQ-025.

Verification (macro undefined unless stated)
REQ-030 Single: req0_in = 1, data0_in = 3 -> next cycle req_out = 1, data_out = 3, grant = 01; ack_in = 1 -> ack0_out = 1; req0_in = 0 and ack_in = 0 -> ack0_out = 0, xfer_cnt = 1.
REQ-031 Simultaneous after reset: req0_in = req1_in = 1, data 5/6 -> requester 0 served first (data_out = 5), then requester 1 (data_out = 6), grant 01 then 10, xfer_cnt = 2.
REQ-032 Fairness: both requests held high across 4 back-to-back transfers -> grant alternates 01, 10, 01, 10.
REQ-033 Reset in SEND: assert rst_n = 0 while req_out = 1 -> req_out, grant, ack outputs and xfer_cnt 0 immediately, without a clock edge.
REQ-034 Wrap: 256 completed transfers -> xfer_cnt returns to 0.
REQ-035 With STAGE_ARBITER_SYNC_EN: req0_in rises -> req_out rises 3 cycles later instead of 1.

Source files
------------

// File: rtl/stage_arbiter.sv
// stage_arbiter: two-requester round-robin arbiter in front of a shared pipeline stage.
// Each side uses a four-phase req/ack handshake. The FSM (IDLE -> SEND -> RELEASE) grants
// one requester at a time. It forwards that requester's data to the stage, returns the
// stage ack to the owner, and counts completed transfers. All outputs are registered.
//
// Optional feature: define STAGE_ARBITER_SYNC_EN to pass req0_in, req1_in and ack_in
// through two-flop synchronizers before the FSM. Each handshake response then takes
// two extra cycles. By default the FSM samples these inputs directly.
//
// Ports:
//   clk        clock, all state changes on rising edge
//   rst_n      asynchronous active-low reset
//   req0_in    requester 0 request          data0_in  requester 0 data
//   ack0_out   acknowledge to requester 0
//   req1_in    requester 1 request          data1_in  requester 1 data
//   ack1_out   acknowledge to requester 1
//   req_out    request to shared stage      data_out  data to shared stage
//   ack_in     acknowledge from shared stage
//   grant      one-hot owner (bit0 = requester 0), 2'b00 when idle
//   xfer_cnt   completed transfer count, wraps 255 -> 0
module stage_arbiter #(
    parameter int unsigned DATA_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_in,
    input  logic [DATA_WIDTH-1:0] data0_in,
    output logic                  ack0_out,
    input  logic                  req1_in,
    input  logic [DATA_WIDTH-1:0] data1_in,
    output logic                  ack1_out,
    output logic                  req_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ack_in,
    output logic [1:0]            grant,
    output logic [7:0]            xfer_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    // Handshake inputs as seen by the FSM
    logic req0_s, req1_s, ack_s;

`ifdef STAGE_ARBITER_SYNC_EN
    logic [2:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= {ack_in, req1_in, req0_in};
            sync2_q <= sync1_q;
        end
    end

    assign {ack_s, req1_s, req0_s} = sync2_q;
`else
    assign req0_s = req0_in;
    assign req1_s = req1_in;
    assign ack_s  = ack_in;
`endif

    logic [1:0]            state_q, state_d;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            grant_q, grant_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  last_q, last_d;   // index of the requester served last
    logic                  win1;             // requester 1 wins this arbitration
    logic                  owner_req;        // request line of the current owner

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        data_d    = data_q;
        grant_d   = grant_q;
        ack0_d    = ack0_q;
        ack1_d    = ack1_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        // On a tie, serve the requester that did not go last; otherwise serve whoever asks.
        win1      = (req0_s && req1_s) ? ~last_q : ~req0_s;
        owner_req = grant_q[1] ? req1_s : req0_s;

        unique case (state_q)
            IDLE: begin
                if (req0_s || req1_s) begin
                    data_d  = win1 ? data1_in : data0_in;
                    req_d   = 1'b1;
                    grant_d = win1 ? 2'b10 : 2'b01;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    ack0_d  = grant_q[0];
                    ack1_d  = grant_q[1];
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // The transfer completes only when both sides have returned to zero.
                if (!owner_req && !ack_s) begin
                    ack0_d  = 1'b0;
                    ack1_d  = 1'b0;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
                    cnt_d   = cnt_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            grant_q <= 2'b00;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            cnt_q   <= 8'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign req_out  = req_q;
    assign data_out = data_q;
    assign grant    = grant_q;
    assign ack0_out = ack0_q;
    assign ack1_out = ack1_q;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_stage_arbiter.sv
// tb_stage_arbiter: scoreboard bench for stage_arbiter (default build, no synchronizers).
// Requesters push their data into per-requester expectation queues when they raise
// req. A monitor observes grants, acks and completions at negedge. It checks them
// against a transaction-level model: tie -> alternate, single -> that one, count
// completions modulo 256.
module tb_stage_arbiter;

    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_in, req1_in, ack_in;
    logic [DW-1:0] data0_in, data1_in;
    logic          ack0_out, ack1_out, req_out;
    logic [DW-1:0] data_out;
    logic [1:0]    grant;
    logic [7:0]    xfer_cnt;

    int vectors     = 0;
    int miscompares = 0;

    stage_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0_in  (req0_in),
        .data0_in (data0_in),
        .ack0_out (ack0_out),
        .req1_in  (req1_in),
        .data1_in (data1_in),
        .ack1_out (ack1_out),
        .req_out  (req_out),
        .data_out (data_out),
        .ack_in   (ack_in),
        .grant    (grant),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard state
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    int            model_cnt  = 0;
    logic          model_last = 1'b1;
    logic [1:0]    samp_r     = 2'b00;   // {req1,req0} as seen at the latest rising edge
    logic          p_req = 1'b0, p_a0 = 1'b0, p_a1 = 1'b0;

    always @(posedge clk) samp_r = {req1_in, req0_in};

    // Monitor
    always @(negedge clk) begin
        logic [1:0]    exp_owner;
        logic [DW-1:0] exp_d;
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            model_cnt  = 0;
            model_last = 1'b1;
            p_req = 1'b0; p_a0 = 1'b0; p_a1 = 1'b0;
        end else begin
            if (req_out && !p_req) begin
                if (samp_r == 2'b11) exp_owner = model_last ? 2'b01 : 2'b10;
                else                 exp_owner = samp_r;
                check("grant_owner", int'(grant), int'(exp_owner));
                if (grant == 2'b01 && exp_q0.size() > 0) begin
                    exp_d = exp_q0.pop_front();
                    check("data_out_req0", int'(data_out), int'(exp_d));
                end else if (grant == 2'b10 && exp_q1.size() > 0) begin
                    exp_d = exp_q1.pop_front();
                    check("data_out_req1", int'(data_out), int'(exp_d));
                end else begin
                    check("grant_without_pending_request", 1, 0);
                end
            end
            if (ack0_out && !p_a0)
                check("ack0_rise {ack1,ack0,grant,req_out}",
                      int'({ack1_out, ack0_out, grant, req_out}), int'({1'b0, 1'b1, 2'b01, 1'b0}));
            if (ack1_out && !p_a1)
                check("ack1_rise {ack1,ack0,grant,req_out}",
                      int'({ack1_out, ack0_out, grant, req_out}), int'({1'b1, 1'b0, 2'b10, 1'b0}));
            if ((!ack0_out && p_a0) || (!ack1_out && p_a1)) begin
                model_cnt++;
                model_last = p_a1;
                check("xfer_cnt", int'(xfer_cnt), model_cnt % 256);
                check("grant_idle_after_release", int'(grant), 0);
            end
            p_req = req_out; p_a0 = ack0_out; p_a1 = ack1_out;
        end
    end

    // Shared stage: acks each req_out after a random delay, releases after req_out drops.
    logic resp_en = 1'b0;
    initial begin
        int dly = 0;
        ack_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!resp_en || !rst_n) ack_in = 1'b0;
            else if (dly > 0) dly--;
            else if (!ack_in && req_out) begin
                ack_in = 1'b1;
                dly = $urandom_range(0, 3);
            end else if (ack_in && !req_out) begin
                ack_in = 1'b0;
                dly = $urandom_range(0, 3);
            end
        end
    end

    task automatic wait_ack(input int id, input logic lvl);
        int n = 0;
        while (((id == 0) ? ack0_out : ack1_out) != lvl && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("ack_wait_timeout", 0, 1);
    endtask

    // One full four-phase transaction from requester id.
    task automatic do_req(input int id, input logic [DW-1:0] d, input int dly);
        repeat (dly) @(negedge clk);
        if (id == 0) begin
            data0_in = d; exp_q0.push_back(d); req0_in = 1'b1;
        end else begin
            data1_in = d; exp_q1.push_back(d); req1_in = 1'b1;
        end
        wait_ack(id, 1'b1);
        if (id == 0) req0_in = 1'b0;
        else         req1_in = 1'b0;
        wait_ack(id, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        req0_in = 1'b0; req1_in = 1'b0;
        data0_in = '0;  data1_in = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_req_out", int'(req_out), 0);
        check("reset_ack0", int'(ack0_out), 0);
        check("reset_ack1", int'(ack1_out), 0);
        check("reset_grant", int'(grant), 0);
        check("reset_data_out", int'(data_out), 0);
        check("reset_xfer_cnt", int'(xfer_cnt), 0);
        rst_n = 1'b1;
        resp_en = 1'b1;
        @(negedge clk);

        // Simultaneous requests after reset: requester 0 first, then 1.
        fork
            do_req(0, 3'd5, 0);
            do_req(1, 3'd6, 0);
        join
        repeat (2) @(negedge clk);
        check("xfer_cnt_after_two", int'(xfer_cnt), 2);

        // Back-to-back contention to exercise alternation.
        fork
            begin repeat (2) do_req(0, DW'($urandom_range(0, 7)), 0); end
            begin repeat (2) do_req(1, DW'($urandom_range(0, 7)), 0); end
        join

        // Random traffic, enough completions to wrap the counter.
        fork
            begin
                for (int i = 0; i < 140; i++)
                    do_req(0, DW'($urandom_range(0, 7)), $urandom_range(0, 4));
            end
            begin
                for (int j = 0; j < 140; j++)
                    do_req(1, DW'($urandom_range(0, 7)), $urandom_range(0, 4));
            end
        join
        repeat (2) @(negedge clk);
        check("xfer_cnt_wrapped", int'(xfer_cnt), model_cnt % 256);

        // Reset while in SEND: outputs clear without a clock edge.
        resp_en = 1'b0;
        repeat (2) @(negedge clk);
        data0_in = 3'd3; exp_q0.push_back(3'd3); req0_in = 1'b1;
        for (int k = 0; k < 20 && !req_out; k++) @(negedge clk);
        check("reached_send", int'(req_out), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req_out", int'(req_out), 0);
        check("async_rst_grant", int'(grant), 0);
        check("async_rst_acks", int'({ack1_out, ack0_out}), 0);
        check("async_rst_xfer_cnt", int'(xfer_cnt), 0);
        req0_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        resp_en = 1'b1;
        @(negedge clk);

        // Single transfer after reset.
        do_req(0, 3'd3, 0);
        repeat (2) @(negedge clk);
        check("xfer_cnt_single", int'(xfer_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
